// File: rtl/matrix_input_loader.sv
// Input stage of the FP matrix multiplier: packs streamed A (row-major) and B
// (transposed to column-major) elements into flat buses, then pulses load.
module matrix_input_loader #(
    parameter int NUM_FIRST_ROW  = 2,
    parameter int NUM_FIRST_COL  = 2,
    parameter int NUM_SECOND_COL = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          flush,
    input  logic [31:0]                                   in_data,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    output logic [32*NUM_FIRST_ROW*NUM_FIRST_COL-1:0]     In1,
    output logic [32*NUM_FIRST_COL*NUM_SECOND_COL-1:0]    In2,
    output logic                                          load,
    input  logic                                          mm_done,
    output logic                                          busy
);

    localparam int L1     = 32 * NUM_FIRST_ROW * NUM_FIRST_COL;
    localparam int L2     = 32 * NUM_FIRST_COL * NUM_SECOND_COL;
    localparam int NA     = NUM_FIRST_ROW * NUM_FIRST_COL;
    localparam int NB     = NUM_FIRST_COL * NUM_SECOND_COL;
    localparam int ROWMAX = (NUM_FIRST_ROW > NUM_FIRST_COL) ? NUM_FIRST_ROW : NUM_FIRST_COL;
    localparam int COLMAX = (NUM_FIRST_COL > NUM_SECOND_COL) ? NUM_FIRST_COL : NUM_SECOND_COL;
    localparam int RW     = (ROWMAX > 1) ? $clog2(ROWMAX) : 1;
    localparam int CW     = (COLMAX > 1) ? $clog2(COLMAX) : 1;

    localparam logic [RW-1:0] A_ROW_LAST = RW'(NUM_FIRST_ROW - 1);
    localparam logic [CW-1:0] A_COL_LAST = CW'(NUM_FIRST_COL - 1);
    localparam logic [RW-1:0] B_ROW_LAST = RW'(NUM_FIRST_COL - 1);
    localparam logic [CW-1:0] B_COL_LAST = CW'(NUM_SECOND_COL - 1);

    typedef enum logic [1:0] {
        FILL_A    = 2'd0,
        FILL_B    = 2'd1,
        LOAD      = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [RW-1:0]   r_row;
    logic [CW-1:0]   r_col;
    logic [L1-1:0]   r_in1;
    logic [L2-1:0]   r_in2;

    logic            w_fill;
    logic            w_xfer;
    logic            w_endA;
    logic            w_endB;
    logic [CW-1:0]   w_colLast;
    int              w_slotA;
    int              w_slotB;

    // in_ready comes from state alone; rst gating keeps it low while held in reset
    assign w_fill    = rst && ((r_state == FILL_A) || (r_state == FILL_B));
    assign w_xfer    = in_valid && w_fill;
    assign w_endA    = (r_state == FILL_A) && (r_row == A_ROW_LAST) && (r_col == A_COL_LAST);
    assign w_endB    = (r_state == FILL_B) && (r_row == B_ROW_LAST) && (r_col == B_COL_LAST);
    assign w_colLast = (r_state == FILL_B) ? B_COL_LAST : A_COL_LAST;

    always_comb begin
        w_slotA = int'(r_row) * NUM_FIRST_COL + int'(r_col);
        w_slotB = int'(r_col) * NUM_FIRST_COL + int'(r_row);
    end

    always_comb begin
        w_next   = r_state;
        in_ready = w_fill;
        load     = 1'b0;
        busy     = 1'b0;
        case (r_state)
            FILL_A: begin
                if (w_xfer && w_endA) w_next = FILL_B;
            end
            FILL_B: begin
                if (w_xfer && w_endB) w_next = LOAD;
            end
            LOAD: begin
                load   = 1'b1;
                busy   = 1'b1;
                w_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                busy = 1'b1;
                if (mm_done) w_next = FILL_A;
            end
            default: w_next = FILL_A;
        endcase
        if (flush) w_next = FILL_A;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FILL_A;
        end else begin
            r_state <= w_next;
        end
    end

    // Counters clear on flush or at the end of each matrix; otherwise column wraps into row
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (flush || (w_xfer && (w_endA || w_endB))) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_xfer) begin
            if (r_col == w_colLast) begin
                r_col <= '0;
                r_row <= r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in1 <= '0;
            r_in2 <= '0;
        end else if (w_xfer && !flush) begin
            for (int s = 0; s < NA; s++) begin
                if ((r_state == FILL_A) && (w_slotA == s)) r_in1[L1-1-32*s -: 32] <= in_data;
            end
            for (int s = 0; s < NB; s++) begin
                if ((r_state == FILL_B) && (w_slotB == s)) r_in2[L2-1-32*s -: 32] <= in_data;
            end
        end
    end

    assign In1 = r_in1;
    assign In2 = r_in2;

endmodule
